// File: rtl/rv_ctrl_pkg.sv
// Shared opcodes, FSM states and datapath select encodings for the multi-cycle RV32I control unit.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        StFetch, StDecode, StExecR, StExecI, StAddr, StMemRd, StMemWr, StLoadWb,
        StAluWb, StBranch, StJal, StJalr, StLui, StAuipc, StIllegal, StHalt
    } state_e;

    typedef enum logic [1:0] {AluAPc = 2'b00, AluAOldPc = 2'b01, AluARs1 = 2'b10} alu_src_a_e;
    typedef enum logic [1:0] {AluBRs2 = 2'b00, AluBFour = 2'b01, AluBImm = 2'b10} alu_src_b_e;
    typedef enum logic [1:0] {
        AluOpAdd = 2'b00, AluOpBranch = 2'b01, AluOpRType = 2'b10, AluOpIType = 2'b11
    } aluop_e;
    typedef enum logic [1:0] {WbAluOut = 2'b00, WbMdr = 2'b01, WbPc = 2'b10, WbImm = 2'b11} memtoreg_e;

    // One-hot instruction class; all-zero means illegal.
    typedef struct packed {
        logic r;
        logic i;
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
        logic lui;
        logic auipc;
    } op_class_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multi-cycle FSM (master) and the datapath/memory side (slave).
interface multicycle_control_unit_if;

    logic [31:0] instr;
    logic        mem_ready;
    logic        mem_req;
    logic        iord;
    logic        memread;
    logic        memwrite;
    logic        ir_write;
    logic        pc_write;
    logic        branch;
    logic        pc_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  aluop;
    logic        regwrite;
    logic [1:0]  memtoreg;
    logic        illegal;
    logic        retire;

    modport master (
        input  instr, mem_ready,
        output mem_req, iord, memread, memwrite, ir_write, pc_write, branch, pc_src,
               alu_src_a, alu_src_b, aluop, regwrite, memtoreg, illegal, retire
    );

    modport slave (
        output instr, mem_ready,
        input  mem_req, iord, memread, memwrite, ir_write, pc_write, branch, pc_src,
               alu_src_a, alu_src_b, aluop, regwrite, memtoreg, illegal, retire
    );

endinterface

// File: rtl/opcode_class_decoder.sv
// Maps a 7-bit RV32I opcode to a one-hot instruction class; JAL/JALR/LUI/AUIPC gated by ENABLE_JU.
module opcode_class_decoder
    import rv_ctrl_pkg::*;
#(
    parameter bit ENABLE_JU = 1'b1
) (
    input  logic [6:0] i_opcode,
    output op_class_t  o_class,
    output logic       o_illegal
);

    always_comb begin
        o_class = '0;
        case (i_opcode)
            OP_R:      o_class.r      = 1'b1;
            OP_I:      o_class.i      = 1'b1;
            OP_LOAD:   o_class.load   = 1'b1;
            OP_STORE:  o_class.store  = 1'b1;
            OP_BRANCH: o_class.branch = 1'b1;
            OP_JAL:    o_class.jal    = ENABLE_JU;
            OP_JALR:   o_class.jalr   = ENABLE_JU;
            OP_LUI:    o_class.lui    = ENABLE_JU;
            OP_AUIPC:  o_class.auipc  = ENABLE_JU;
            default:   o_class        = '0;
        endcase
        o_illegal = ~|o_class;
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I main control FSM: Moore selects per state, Mealy IR/PC writes and memory exits
// on mem_ready, all outputs forced low while rst is high.
module multicycle_control_unit
    import rv_ctrl_pkg::*;
#(
    parameter bit ENABLE_JU    = 1'b1,
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    multicycle_control_unit_if.master   bus
);

    state_e    r_state;
    state_e    w_state_next;
    op_class_t w_class;
    logic      w_illegal;
    logic      w_unused;

    assign w_unused = ^bus.instr[31:7];

    opcode_class_decoder #(
        .ENABLE_JU (ENABLE_JU)
    ) u_decoder (
        .i_opcode  (bus.instr[6:0]),
        .o_class   (w_class),
        .o_illegal (w_illegal)
    );

    always_comb begin
        w_state_next  = r_state;
        bus.mem_req   = 1'b0;
        bus.iord      = 1'b0;
        bus.memread   = 1'b0;
        bus.memwrite  = 1'b0;
        bus.ir_write  = 1'b0;
        bus.pc_write  = 1'b0;
        bus.branch    = 1'b0;
        bus.pc_src    = 1'b0;
        bus.alu_src_a = AluAPc;
        bus.alu_src_b = AluBRs2;
        bus.aluop     = AluOpAdd;
        bus.regwrite  = 1'b0;
        bus.memtoreg  = WbAluOut;
        bus.illegal   = 1'b0;
        bus.retire    = 1'b0;
        if (!rst) begin
            unique case (r_state)
                StFetch: begin
                    bus.mem_req   = 1'b1;
                    bus.alu_src_b = AluBFour;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        w_state_next = StDecode;
                    end
                end
                StDecode: begin
                    bus.alu_src_a = AluAOldPc;
                    bus.alu_src_b = AluBImm;
                    if (w_illegal) begin
                        w_state_next = StIllegal;
                    end else begin
                        unique case (1'b1)
                            w_class.r:                w_state_next = StExecR;
                            w_class.i:                w_state_next = StExecI;
                            w_class.load, w_class.store: w_state_next = StAddr;
                            w_class.branch:           w_state_next = StBranch;
                            w_class.jal:              w_state_next = StJal;
                            w_class.jalr:             w_state_next = StJalr;
                            w_class.lui:              w_state_next = StLui;
                            w_class.auipc:            w_state_next = StAuipc;
                        endcase
                    end
                end
                StExecR: begin
                    bus.alu_src_a = AluARs1;
                    bus.alu_src_b = AluBRs2;
                    bus.aluop     = AluOpRType;
                    w_state_next  = StAluWb;
                end
                StExecI: begin
                    bus.alu_src_a = AluARs1;
                    bus.alu_src_b = AluBImm;
                    bus.aluop     = AluOpIType;
                    w_state_next  = StAluWb;
                end
                StAddr: begin
                    bus.alu_src_a = AluARs1;
                    bus.alu_src_b = AluBImm;
                    w_state_next  = w_class.store ? StMemWr : StMemRd;
                end
                StMemRd: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                    bus.memread = 1'b1;
                    if (bus.mem_ready) w_state_next = StLoadWb;
                end
                StMemWr: begin
                    bus.mem_req  = 1'b1;
                    bus.iord     = 1'b1;
                    bus.memwrite = 1'b1;
                    if (bus.mem_ready) w_state_next = StFetch;
                end
                StLoadWb: begin
                    bus.regwrite = 1'b1;
                    bus.memtoreg = WbMdr;
                    w_state_next = StFetch;
                end
                StAluWb, StAuipc: begin
                    bus.regwrite = 1'b1;
                    bus.memtoreg = WbAluOut;
                    w_state_next = StFetch;
                end
                StBranch: begin
                    bus.alu_src_a = AluARs1;
                    bus.alu_src_b = AluBRs2;
                    bus.aluop     = AluOpBranch;
                    bus.branch    = 1'b1;
                    bus.pc_src    = 1'b1;
                    w_state_next  = StFetch;
                end
                StJal: begin
                    bus.regwrite = 1'b1;
                    bus.memtoreg = WbPc;
                    bus.pc_write = 1'b1;
                    bus.pc_src   = 1'b1;
                    w_state_next = StFetch;
                end
                StJalr: begin
                    // Register file captures the old PC (already +4) while the PC takes RS1+IMM.
                    bus.alu_src_a = AluARs1;
                    bus.alu_src_b = AluBImm;
                    bus.pc_write  = 1'b1;
                    bus.regwrite  = 1'b1;
                    bus.memtoreg  = WbPc;
                    w_state_next  = StFetch;
                end
                StLui: begin
                    bus.regwrite = 1'b1;
                    bus.memtoreg = WbImm;
                    w_state_next = StFetch;
                end
                StIllegal: begin
                    bus.illegal  = 1'b1;
                    w_state_next = ILLEGAL_HALT ? StHalt : StFetch;
                end
                StHalt: w_state_next = StHalt;
            endcase
            bus.retire = (r_state != StFetch) && (r_state != StIllegal) &&
                         (w_state_next == StFetch);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= StFetch;
        else     r_state <= w_state_next;
    end

endmodule
